// File: rtl/block_bram_loader_pkg.sv
// Shared definitions for the block BRAM loader: FSM encoding, block size and
// the field layout of a packed pixel-pair word.
package block_bram_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    localparam int BLOCK_WORDS = 2048;

    // Word layout: {ref0, colour0, pixel0, ref1, colour1, pixel1}
    localparam int REF0_LSB = 24;
    localparam int COL0_LSB = 22;
    localparam int PIX0_LSB = 16;
    localparam int REF1_LSB = 8;
    localparam int COL1_LSB = 6;
    localparam int PIX1_LSB = 0;
    localparam int REF_W    = 8;
    localparam int COL_W    = 2;
    localparam int PIX_W    = 6;

endpackage

// File: rtl/block_bram_loader_if.sv
// AXI-Stream style pixel-word channel feeding the block BRAM loader.
interface block_bram_loader_if;

    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);

endinterface

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle counter for the loader: cleared on activity, counts while enabled,
// flags terminal count once TIMEOUT_CYCLES idle cycles have elapsed.
module loader_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic pclk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // Saturates at terminal count so tc stays asserted until cleared.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/block_bram_loader.sv
// Loads one block of pixel-pair words from a stream into the display BRAM.
// Define BLOCK_LOADER_PINGPONG_EN for two-bank ping-pong operation.
module block_bram_loader
    import block_bram_loader_pkg::*;
#(
    parameter int WORDS          = BLOCK_WORDS,
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic                block_req,
    block_bram_loader_if.slave  s_axis,
    output logic [31:0]         bram_addr,
    output logic [31:0]         bram_wrdata,
    output logic                bram_en,
    output logic [3:0]          bram_we,
    output logic                busy,
    output logic                load_done,
    output logic                err_short,
    output logic                err_long,
    output logic                err_timeout,
    output logic                req_dropped,
    output logic                rd_bank
);

    load_state_t       state;
    logic              req_q;
    logic              tready;
    logic [ADDR_W-1:0] index;
    logic              start;
    logic              beat;
    logic              last_idx;
    logic              tc;
    logic              wr_bank;

    assign start    = block_req & ~req_q;
    assign beat     = s_axis.s_tvalid & tready;
    assign last_idx = (index == ADDR_W'(WORDS - 1));
    assign s_axis.s_tready = tready;

    // Counts only while accepting; any beat or leaving LOAD/FLUSH restarts it.
    loader_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .pclk  (pclk),
        .reset (reset),
        .clr   (beat | ~tready),
        .en    (tready),
        .tc    (tc)
    );

`ifdef BLOCK_LOADER_PINGPONG_EN
    // Only a clean end of block hands the freshly written bank to the reader.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rd_bank <= 1'b0;
        end else if (state == ST_LOAD && beat && last_idx && s_axis.s_tlast) begin
            rd_bank <= ~rd_bank;
        end
    end
    assign wr_bank = ~rd_bank;
`else
    assign rd_bank = 1'b0;
    assign wr_bank = 1'b0;
`endif

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            req_q       <= 1'b0;
            index       <= '0;
            tready      <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_timeout <= 1'b0;
            req_dropped <= 1'b0;
            bram_en     <= 1'b0;
            bram_we     <= 4'h0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
        end else begin
            req_q       <= block_req;
            load_done   <= 1'b0;
            bram_en     <= 1'b0;
            bram_we     <= 4'h0;
            req_dropped <= start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_LOAD;
                        index       <= '0;
                        tready      <= 1'b1;
                        busy        <= 1'b1;
                        err_short   <= 1'b0;
                        err_long    <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        bram_en     <= 1'b1;
                        bram_we     <= 4'hF;
                        bram_addr   <= {{(31 - ADDR_W){1'b0}}, wr_bank, index};
                        bram_wrdata <= s_axis.s_tdata;
                        if (last_idx && !s_axis.s_tlast) begin
                            // Over-long block: drain the remainder without writing.
                            err_long <= 1'b1;
                            state    <= ST_FLUSH;
                        end else if (last_idx || s_axis.s_tlast) begin
                            err_short <= !last_idx;
                            state     <= ST_DONE;
                            tready    <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end else if (tc) begin
                        err_timeout <= 1'b1;
                        state       <= ST_DONE;
                        tready      <= 1'b0;
                        load_done   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if ((beat && s_axis.s_tlast) || (!beat && tc)) begin
                        err_timeout <= !beat;
                        state       <= ST_DONE;
                        tready      <= 1'b0;
                        load_done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_bram_loader.sv
// Randomized scoreboard bench for block_bram_loader (either bank configuration).
module tb_block_bram_loader;
    import block_bram_loader_pkg::*;

    localparam int WORDS   = 2048;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 4096;
`ifdef BLOCK_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic        block_req = 1'b0;
    logic [31:0] bram_addr, bram_wrdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic        busy, load_done, err_short, err_long, err_timeout, req_dropped, rd_bank;

    block_bram_loader_if s_axis();

    block_bram_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .block_req   (block_req),
        .s_axis      (s_axis),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .busy        (busy),
        .load_done   (load_done),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_timeout (err_timeout),
        .req_dropped (req_dropped),
        .rd_bank     (rd_bank)
    );

    always #5 pclk = ~pclk;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic s; logic l; logic t; logic bank; } done_t;

    int    checks = 0;
    int    errors = 0;
    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    drops_seen = 0;
    int    exp_drops = 0;
    bit    model_bank = 1'b0;
    wr_t   got_w;
    done_t got_d;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [31:0] word_addr(int k, bit b);
        logic [31:0] a;
        a = 32'(k);
        a[ADDR_W] = b;
        return a;
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT writes or finishes.
    always @(negedge pclk) begin
        if (reset) begin
            if (bram_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected actual addr=%h data=%h required no write", bram_addr, bram_wrdata);
                end else begin
                    got_w = exp_wr.pop_front();
                    check("write_addr", bram_addr, got_w.addr);
                    check("write_data", bram_wrdata, got_w.data);
                    check("write_we", 32'(bram_we), 32'hF);
                end
            end
            if (load_done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected actual load_done=1 required 0");
                end else begin
                    got_d = exp_done.pop_front();
                    check("done_err_short", 32'(err_short), 32'(got_d.s));
                    check("done_err_long", 32'(err_long), 32'(got_d.l));
                    check("done_err_timeout", 32'(err_timeout), 32'(got_d.t));
                    check("done_rd_bank", 32'(rd_bank), 32'(got_d.bank));
                    check("done_busy", 32'(busy), 32'd1);
                end
            end
            if (req_dropped) drops_seen++;
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_addr"}, bram_addr, 32'd0);
        check({tag, "_wrdata"}, bram_wrdata, 32'd0);
        check({tag, "_en_we"}, {27'd0, bram_en, bram_we}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, load_done}, 32'd0);
        check({tag, "_errs"}, {29'd0, err_short, err_long, err_timeout}, 32'd0);
        check({tag, "_drop_bank"}, {30'd0, req_dropped, rd_bank}, 32'd0);
        check({tag, "_tready"}, 32'(s_axis.s_tready), 32'd0);
    endtask

    task automatic send_beat(input logic [31:0] data, input bit last, output bit ok);
        bit rdy;
        s_axis.s_tvalid = 1'b1;
        s_axis.s_tdata  = data;
        s_axis.s_tlast  = last;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge pclk);
            rdy = s_axis.s_tready;
            @(posedge pclk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_axis.s_tvalid = 1'b0;
        s_axis.s_tlast  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept actual tready=0 for 50 cycles required 1");
        end
    endtask

    // Reference: a block ends at its first tlast; only the first WORDS beats are written.
    task automatic run_load(input int nbeats, input int tlast_at, input bit rnd, input bit gaps,
                            input int drop_at, input int abort_at);
        int nwr;
        bit ok, wbank;
        logic [31:0] d;
        nwr   = (tlast_at >= 0 && tlast_at < WORDS - 1) ? tlast_at + 1 : WORDS;
        wbank = PP ? ~model_bank : 1'b0;
        block_req = 1'b1;
        repeat (3) tick();
        block_req = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            if (k == drop_at) begin
                block_req = 1'b1;
                exp_drops++;
            end else if (k == drop_at + 1) begin
                block_req = 1'b0;
            end
            if (k == abort_at) begin
                @(negedge pclk);
                #1 reset = 1'b0;
                #1 check_all_zero("abort_async");
                tick();
                check_all_zero("abort_edge");
                model_bank = 1'b0;
                tick();
                reset = 1'b1;
                tick();
                return;
            end
            d = rnd ? $urandom : 32'(k);
            send_beat(d, k == tlast_at, ok);
            if (!ok) return;
            if (k < nwr) exp_wr.push_back('{addr: word_addr(k, wbank), data: d});
            if (k == tlast_at) begin
                if (PP && tlast_at == WORDS - 1) model_bank = ~model_bank;
                exp_done.push_back('{s: tlast_at < WORDS - 1, l: tlast_at > WORDS - 1, t: 1'b0, bank: model_bank});
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int c = 0; c < budget; c++) begin
            if (!busy) break;
            tick();
        end
        repeat (4) tick();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_tready"}, 32'(s_axis.s_tready), 32'd0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.s_tvalid = 1'b0;
        s_axis.s_tlast  = 1'b0;
        s_axis.s_tdata  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        // Full clean block, data equals address
        run_load(WORDS, WORDS - 1, 1'b0, 1'b0, -1, -1);
        wait_idle(100, "clean");
        check("clean_errs", {29'd0, err_short, err_long, err_timeout}, 32'd0);

        // Short block
        run_load(100, 99, 1'b1, 1'b1, -1, -1);
        wait_idle(100, "short");
        check("short_sticky", 32'(err_short), 32'd1);

        // Long block, tail flushed
        run_load(WORDS + 5, WORDS + 4, 1'b1, 1'b1, -1, -1);
        wait_idle(100, "long");
        check("long_sticky", 32'(err_long), 32'd1);

        // Stall after beat 10
        run_load(11, -1, 1'b1, 1'b0, -1, -1);
        exp_done.push_back('{s: 1'b0, l: 1'b0, t: 1'b1, bank: model_bank});
        wait_idle(TIMEOUT + 200, "timeout");
        check("timeout_sticky", 32'(err_timeout), 32'd1);

        // Request edge mid-load is dropped, load completes cleanly
        run_load(WORDS, WORDS - 1, 1'b1, 1'b1, 300, -1);
        wait_idle(100, "drop");
        check("drop_count", 32'(drops_seen), 32'(exp_drops));

        // Two more clean loads, then reset abandons a load at beat 500
        run_load(WORDS, WORDS - 1, 1'b1, 1'b1, -1, -1);
        wait_idle(100, "pp_a");
        run_load(WORDS, WORDS - 1, 1'b1, 1'b0, -1, -1);
        wait_idle(100, "pp_b");
        check("pp_bank", 32'(rd_bank), 32'(model_bank));
        run_load(WORDS, WORDS - 1, 1'b1, 1'b0, -1, 500);
        check("abort_bank", 32'(rd_bank), 32'd0);

        // Recovery after reset
        run_load(10, 9, 1'b1, 1'b1, -1, -1);
        wait_idle(100, "recover");

        repeat (5) tick();
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        check("drop_total", 32'(drops_seen), 32'(exp_drops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
